// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, state encoding and size/alignment helpers for the memory-stage LSU.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t;
  function automatic logic is_byte(logic [2:0] f3);
    return f3 == F3_B || f3 == F3_BU;
  endfunction
  function automatic logic is_half(logic [2:0] f3);
    return f3 == F3_H || f3 == F3_HU;
  endfunction
  // Unlisted funct3 codes fall through to word size.
  function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] a);
    return is_half(f3) ? a[0] : !is_byte(f3) && a != 2'b00;
  endfunction
endpackage

// File: rtl/ld_fmt.sv
// ld_fmt: picks the addressed byte/half lane of a read word and sign/zero-extends it.
module ld_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = rdata[{addr[1], 4'b0000} +: 16];
  assign data = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                funct3 == F3_BU ? {24'b0, b}       :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h}       : rdata;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit; issues one word-bus access per instruction and stalls until ack or watchdog abort.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readm,
  input  logic        memWrtm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  output logic        stallm,
  output logic [31:0] ldDatam,
  output logic        ldVldm,
  output logic        misalgnm,
  output logic        busErrm,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [3:0]  dmBe,
  output logic [31:0] dmWdata,
  input  logic [31:0] dmRdata,
  input  logic        dmAck
);
  lsu_state_t  state_q, state_d;
  logic [31:0] cnt_q, addr_q, wd_q, ld_q, wd_d, fmt;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q;
  logic        we_q, ok_q, err_q;
  logic        access, mis, idle_s, wait_s, go, ack, tmo;

  assign access = readm | memWrtm;
  assign mis    = is_misaligned(funct3m, aluRsltm[1:0]);
  assign idle_s = state_q == IDLE;
  assign wait_s = state_q == WAIT;
  // rst gates the IDLE-state combinational request so a held readm/memWrtm cannot leak through reset.
  assign go     = ~rst & idle_s & access & ~mis;
  assign ack    = wait_s & dmAck;
  assign tmo    = wait_s & ~dmAck & (TMO_CYCLES != 0) & (cnt_q == TMO_CYCLES - 1);

  assign be_d = is_byte(funct3m) ? 4'b0001 << aluRsltm[1:0] :
                is_half(funct3m) ? (aluRsltm[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wd_d = ~memWrtm         ? 32'b0               :
                is_byte(funct3m) ? {4{wrtDm[7:0]}}     :
                is_half(funct3m) ? {2{wrtDm[15:0]}}    : wrtDm;

  ld_fmt u_fmt (.rdata(dmRdata), .addr(addr_q[1:0]), .funct3(f3_q), .data(fmt));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? WAIT : IDLE;
      WAIT:    state_d = ack | tmo ? DONE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        we_q   <= memWrtm;
        addr_q <= aluRsltm;
        be_q   <= be_d;
        wd_q   <= wd_d;
        f3_q   <= funct3m;
        cnt_q  <= '0;
      end else if (wait_s) cnt_q <= cnt_q + 32'd1;
      if (ack) begin
        ok_q  <= ~we_q;
        err_q <= 1'b0;
        if (~we_q) ld_q <= fmt;
      end else if (tmo) begin
        ok_q  <= 1'b0;
        err_q <= 1'b1;
      end
    end

  assign stallm   = go | wait_s;
  assign dmReq    = go | wait_s;
  assign dmWe     = go ? memWrtm : wait_s & we_q;
  assign dmAddr   = go ? {aluRsltm[31:2], 2'b00} : wait_s ? {addr_q[31:2], 2'b00} : 32'b0;
  assign dmBe     = go ? be_d : wait_s ? be_q : 4'b0;
  assign dmWdata  = go ? wd_d : wait_s ? wd_q : 32'b0;
  assign misalgnm = ~rst & idle_s & access & mis;
  assign ldVldm   = state_q == DONE & ok_q;
  assign busErrm  = state_q == DONE & err_q;
  assign ldDatam  = ld_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table plus hand-written misalign, watchdog and mid-access reset sequences.
module tb_mem_lsu;
  logic        clk = 1'b0, rst = 1'b1;
  logic        readm = 1'b0, memWrtm = 1'b0, dmAck = 1'b0;
  logic [2:0]  funct3m = 3'b0;
  logic [31:0] aluRsltm = 32'b0, wrtDm = 32'b0, dmRdata = 32'b0;
  logic        stallm, ldVldm, misalgnm, busErrm, dmReq, dmWe;
  logic [31:0] ldDatam, dmAddr, dmWdata;
  logic [3:0]  dmBe;
  int n_chk = 0, n_fail = 0;

  mem_lsu #(.TMO_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .readm(readm), .memWrtm(memWrtm), .funct3m(funct3m),
    .aluRsltm(aluRsltm), .wrtDm(wrtDm), .stallm(stallm), .ldDatam(ldDatam),
    .ldVldm(ldVldm), .misalgnm(misalgnm), .busErrm(busErrm), .dmReq(dmReq),
    .dmWe(dmWe), .dmAddr(dmAddr), .dmBe(dmBe), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmAck(dmAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wd, rdata;
    int          k;
    logic        we;
    logic [31:0] eaddr;
    logic [3:0]  be;
    logic [31:0] ewd, eld;
    logic        vld;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    readm = 1'b0; memWrtm = 1'b0; funct3m = 3'b0; aluRsltm = 32'b0; wrtDm = 32'b0; dmAck = 1'b0;
  endtask

  task automatic run_tx(input vec_t v);
    int stalls;
    @(negedge clk);
    readm = v.rd; memWrtm = v.wr; funct3m = v.f3; aluRsltm = v.addr; wrtDm = v.wd; dmRdata = v.rdata;
    #1;
    chk("req_issue", {31'b0, dmReq}, 32'd1);
    chk("req_we", {31'b0, dmWe}, {31'b0, v.we});
    chk("req_addr", dmAddr, v.eaddr);
    chk("req_be", {28'b0, dmBe}, {28'b0, v.be});
    chk("req_wdata", dmWdata, v.ewd);
    stalls = int'(stallm);
    for (int i = 1; i <= v.k; i++) begin
      @(negedge clk);
      if (i == 1) begin
        aluRsltm = ~v.addr; wrtDm = ~v.wd;
        #1;
        chk("held_addr", dmAddr, v.eaddr);
        chk("held_wdata", dmWdata, v.ewd);
      end
      stalls += int'(stallm);
      if (i == v.k) dmAck = 1'b1;
    end
    @(negedge clk);
    dmAck = 1'b0;
    #1;
    chk("stall_cycles", stalls, v.k + 1);
    chk("done_stall", {31'b0, stallm}, 32'd0);
    chk("done_req", {31'b0, dmReq}, 32'd0);
    chk("done_ldvld", {31'b0, ldVldm}, {31'b0, v.vld});
    chk("done_lddata", ldDatam, v.eld);
    @(negedge clk);
    clear_in();
    #1;
    chk("after_ldvld", {31'b0, ldVldm}, 32'd0);
  endtask

  initial begin
    //                rd  wr  f3      addr          wd            rdata        k  we  eaddr         be       ewd           eld           vld
    vecs[0]  = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        32'hDEAD_BEEF,2,1'b0,32'h0000_0100,4'b1111,32'h0,        32'hDEAD_BEEF,1'b1};
    vecs[1]  = '{1'b1,1'b0,3'b000,32'h0000_0103,32'h0,        32'h80FF_0000,1,1'b0,32'h0000_0100,4'b1000,32'h0,        32'hFFFF_FF80,1'b1};
    vecs[2]  = '{1'b1,1'b0,3'b100,32'h0000_0103,32'h0,        32'h80FF_0000,1,1'b0,32'h0000_0100,4'b1000,32'h0,        32'h0000_0080,1'b1};
    vecs[3]  = '{1'b0,1'b1,3'b001,32'h0000_0202,32'h1234_ABCD,32'h0,        1,1'b1,32'h0000_0200,4'b1100,32'hABCD_ABCD,32'h0000_0080,1'b0};
    vecs[4]  = '{1'b1,1'b0,3'b001,32'h0000_0102,32'h0,        32'h8001_7FFF,3,1'b0,32'h0000_0100,4'b1100,32'h0,        32'hFFFF_8001,1'b1};
    vecs[5]  = '{1'b1,1'b0,3'b101,32'h0000_0100,32'h0,        32'h8001_F234,1,1'b0,32'h0000_0100,4'b0011,32'h0,        32'h0000_F234,1'b1};
    vecs[6]  = '{1'b0,1'b1,3'b000,32'h0000_0101,32'hAAAA_AA55,32'h0,        2,1'b1,32'h0000_0100,4'b0010,32'h5555_5555,32'h0000_F234,1'b0};
    vecs[7]  = '{1'b0,1'b1,3'b010,32'h0000_0010,32'hCAFE_F00D,32'h0,        1,1'b1,32'h0000_0010,4'b1111,32'hCAFE_F00D,32'h0000_F234,1'b0};
    vecs[8]  = '{1'b1,1'b0,3'b000,32'h0000_0001,32'h0,        32'h0000_7F00,1,1'b0,32'h0000_0000,4'b0010,32'h0,        32'h0000_007F,1'b1};
    vecs[9]  = '{1'b1,1'b1,3'b010,32'h0000_0020,32'h1122_3344,32'h9999_9999,1,1'b1,32'h0000_0020,4'b1111,32'h1122_3344,32'h0000_007F,1'b0};
    vecs[10] = '{1'b1,1'b0,3'b011,32'h0000_0040,32'h0,        32'h8765_4321,3,1'b0,32'h0000_0040,4'b1111,32'h0,        32'h8765_4321,1'b1};
    vecs[11] = '{1'b0,1'b1,3'b010,32'h0000_0000,32'h0BAD_F00D,32'h0,        1,1'b1,32'h0000_0000,4'b1111,32'h0BAD_F00D,32'h0000_0000,1'b0};

    #12;
    chk("rst_stall", {31'b0, stallm}, 32'd0);
    chk("rst_req", {31'b0, dmReq}, 32'd0);
    chk("rst_flags", {28'b0, ldVldm, misalgnm, busErrm, dmWe}, 32'd0);
    chk("rst_lddata", ldDatam, 32'd0);
    chk("rst_bus", dmAddr | dmWdata | {28'b0, dmBe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_tx(vecs[i]);

    @(negedge clk);
    readm = 1'b1; funct3m = 3'b010; aluRsltm = 32'h0000_0105;
    #1;
    chk("mis_req", {31'b0, dmReq}, 32'd0);
    chk("mis_pulse", {31'b0, misalgnm}, 32'd1);
    chk("mis_stall", {31'b0, stallm}, 32'd0);
    @(negedge clk);
    funct3m = 3'b001; aluRsltm = 32'h0000_0101;
    #1;
    chk("mis_half", {31'b0, misalgnm}, 32'd1);
    chk("mis_half_req", {31'b0, dmReq}, 32'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("mis_clear", {31'b0, misalgnm}, 32'd0);
    chk("mis_idle_stall", {31'b0, stallm}, 32'd0);

    @(negedge clk);
    readm = 1'b1; funct3m = 3'b010; aluRsltm = 32'h0000_0300;
    #1;
    chk("tmo_issue", {31'b0, dmReq}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk("tmo_wait_req", {31'b0, dmReq & stallm}, 32'd1);
      chk("tmo_wait_err", {31'b0, busErrm}, 32'd0);
    end
    @(negedge clk);
    dmAck = 1'b1;
    #1;
    chk("tmo_req_drop", {31'b0, dmReq}, 32'd0);
    chk("tmo_buserr", {31'b0, busErrm}, 32'd1);
    chk("tmo_stall", {31'b0, stallm}, 32'd0);
    chk("tmo_ldvld", {31'b0, ldVldm}, 32'd0);
    @(negedge clk);
    clear_in();
    #1;
    chk("tmo_err_pulse", {31'b0, busErrm}, 32'd0);
    chk("tmo_late_ack", {31'b0, ldVldm | dmReq}, 32'd0);
    chk("tmo_lddata_hold", ldDatam, 32'h8765_4321);

    @(negedge clk);
    readm = 1'b1; funct3m = 3'b010; aluRsltm = 32'h0000_0400;
    @(negedge clk);
    #1;
    chk("rst_mid_req", {31'b0, dmReq}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_req0", {31'b0, dmReq}, 32'd0);
    chk("rst_mid_stall0", {31'b0, stallm}, 32'd0);
    chk("rst_mid_ldvld0", {31'b0, ldVldm}, 32'd0);
    @(negedge clk);
    clear_in();
    rst = 1'b0;
    run_tx(vecs[11]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit. Consumes the EX/MEM register outputs: readm, memWrtm, funct3m, aluRsltm as address, wrtDm as store data.
- Drives a word-wide data-memory request/acknowledge bus with byte enables.
- Holds the pipeline via stallm until memory acknowledges.
- Returns sign/zero-extended load data to the MEM/WB register.

Parameters:
- TMO_CYCLES, 255, wait cycles without dmAck before the access is aborted with busErrm; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- readm  in  1  load in MEM stage
- memWrtm  in  1  store in MEM stage
- funct3m  in  3  access size/sign
- aluRsltm  in  32  byte address
- wrtDm  in  32  store data, LSB-justified
- stallm  out  1  hold IF..EX/MEM registers
- ldDatam  out  32  formatted load result
- ldVldm  out  1  ldDatam valid this cycle
- misalgnm  out  1  misaligned access, one-cycle pulse
- busErrm  out  1  watchdog abort, one-cycle pulse
- dmReq  out  1  request, held until dmAck
- dmWe  out  1  1 = write
- dmAddr  out  32  word address, aluRsltm with bits [1:0] forced to 0
- dmBe  out  4  byte enables
- dmWdata  out  32  lane-replicated store data
- dmRdata  in  32  read data, valid with dmAck
- dmAck  in  1  one-cycle acknowledge

Behaviour:
- Reset, asynchronous: state IDLE, watchdog counter 0. All outputs 0: stallm, ldDatam, ldVldm, misalgnm, busErrm, dmReq, dmWe, dmAddr, dmBe, dmWdata.
- access = readm | memWrtm.
- Store priority: if both readm and memWrtm are 1, the access is a store.
- Size decode:
  - funct3 000: byte. 001: half. 010: word. 100: byte unsigned. 101: half unsigned.
  - Any other funct3 value is treated as a word access.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]≠0.
- States: IDLE, WAIT, DONE.
- IDLE:
  - No access: idle, stallm=0.
  - Misaligned access: no dmReq. misalgnm=1 for this cycle only, stallm=0, state stays IDLE.
  - Aligned access: dmReq=1 combinationally with dmWe/dmAddr/dmBe/dmWdata. stallm=1, go WAIT. Request fields are registered at entry and held stable in WAIT.
- WAIT:
  - dmReq=1, stallm=1, watchdog counter increments.
  - On dmAck: load data is formatted and registered into ldDatam; go DONE.
  - Counter reaches TMO_CYCLES with no dmAck: dmReq drops, busErrm=1 for one cycle in DONE, ldVldm=0.
- DONE:
  - dmReq=0, stallm=0.
  - ldVldm=1 for one cycle if the access was a load.
  - The EX/MEM register advances at the end of this cycle; no re-issue. Next state is IDLE.
- Latency: request issued in cycle N, dmAck in cycle N+k (k≥1), result and stall release in cycle N+k+1.
- ldDatam holds its value until the next load completes.
- Byte enables and store data:
  - Byte: dmBe=0001<<addr[1:0], dmWdata={4{wrtDm[7:0]}}.
  - Half: dmBe=addr[1]?1100:0011, dmWdata={2{wrtDm[15:0]}}.
  - Word: dmBe=1111, dmWdata=wrtDm.
  - Loads drive dmBe per size; dmWdata is don't-care, driven 0.
- Load formatting: select the lane by addr[1:0], then sign- or zero-extend to 32 bits per funct3.
- dmAck arriving while not in WAIT is ignored.
- Reset during WAIT: immediate return to IDLE with dmReq=0. The memory side is reset together with this block.

Decomposition:
- Package lsu_pkg:
  - Funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, WAIT, DONE}.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module ld_fmt: combinational lane extract plus extend. Inputs rdata[31:0], addr[1:0], funct3[2:0]; output data[31:0].

Test Plan:
- LW at 0x100, dmAck two cycles after request, dmRdata=0xDEADBEEF -> dmAddr=0x100, dmBe=1111. stallm high 3 cycles. Then ldDatam=0xDEADBEEF with ldVldm=1 for one cycle.
- LB at 0x103, dmRdata=0x80FF_0000 -> dmBe=1000, ldDatam=0xFFFFFF80. LBU at the same address -> ldDatam=0x00000080.
- SH at 0x202, wrtDm=0x1234ABCD -> dmWe=1, dmAddr=0x200, dmBe=1100, dmWdata=0xABCDABCD. ldVldm stays 0.
- LW at 0x105 -> no dmReq, misalgnm=1 for one cycle, stallm=0, state stays IDLE.
- TMO_CYCLES=4, dmAck never asserted -> dmReq drops after 4 WAIT cycles. busErrm pulses once, stallm releases the following cycle.
- rst asserted mid-WAIT -> dmReq, stallm, ldVldm all 0 asynchronously. After release, a fresh SW at 0x0 completes normally.
